// File: rtl/led_row_serializer.sv
// Serializes one pixel row per valid/ready handshake onto din/dclk/strobe for the LED matrix driver.
// Define LED_SER_LSB_FIRST_EN to send row_data[0] first instead of the MSB.
module led_row_serializer #(
   parameter int COLS = 8,
   parameter int ROWS = 8,
   parameter int DIV  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [COLS-1:0]          row_data,
   input  logic [4:0]               row_blank,
   input  logic                     row_valid,
   output logic                     row_ready,
   output logic                     din,
   output logic                     dclk,
   output logic                     strobe,
   output logic [4:0]               blankt,
   output logic [$clog2(ROWS)-1:0]  row_idx,
   output logic                     frame_done
);

   localparam int BW = $clog2(COLS);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int RW = $clog2(ROWS);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, STROBE} state_t;

   state_t          state, state_next;
   logic [COLS-1:0] sr, sr_next, sr_shift;
   logic [BW-1:0]   bit_cnt, bit_next;
   logic [DW-1:0]   div_cnt, div_next;
   logic [RW-1:0]   row_next;
   logic [4:0]      blank_next;
   logic            din_next, dclk_next, strobe_next, fd_next;
   logic            load_bit, cur_bit, next_bit;
   logic            div_last;

   // Bit-order selection: which row_data bit leads, and which sr bit follows a shift
`ifdef LED_SER_LSB_FIRST_EN
   assign load_bit = row_data[0];
   assign cur_bit  = sr[0];
   assign next_bit = sr[1];
   assign sr_shift = {1'b0, sr[COLS-1:1]};
`else
   assign load_bit = row_data[COLS-1];
   assign cur_bit  = sr[COLS-1];
   assign next_bit = sr[COLS-2];
   assign sr_shift = {sr[COLS-2:0], 1'b0};
`endif

   assign div_last  = (div_cnt == DIV_LAST);
   assign row_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sr         <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         row_idx    <= '0;
         blankt     <= '0;
         din        <= 1'b0;
         dclk       <= 1'b0;
         strobe     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         sr         <= sr_next;
         bit_cnt    <= bit_next;
         div_cnt    <= div_next;
         row_idx    <= row_next;
         blankt     <= blank_next;
         din        <= din_next;
         dclk       <= dclk_next;
         strobe     <= strobe_next;
         frame_done <= fd_next;
      end
   end

   // Outputs are computed one cycle ahead so the pins come straight from flops
   always_comb begin
      state_next  = state;
      sr_next     = sr;
      bit_next    = bit_cnt;
      div_next    = div_cnt;
      row_next    = row_idx;
      blank_next  = blankt;
      din_next    = din;
      dclk_next   = dclk;
      strobe_next = 1'b0;
      fd_next     = 1'b0;
      case (state)
         IDLE: begin
            if (row_valid) begin
               sr_next    = row_data;
               blank_next = row_blank;
               bit_next   = '0;
               div_next   = '0;
               din_next   = load_bit;
               dclk_next  = 1'b0;
               state_next = LOW;
            end
         end
         LOW: begin
            din_next = cur_bit;
            if (div_last) begin
               div_next   = '0;
               dclk_next  = 1'b1;
               state_next = HIGH;
            end else begin
               div_next = div_cnt + 1'b1;
            end
         end
         HIGH: begin
            din_next = cur_bit;
            if (div_last) begin
               div_next  = '0;
               dclk_next = 1'b0;
               if (bit_cnt == BIT_LAST) begin
                  din_next    = 1'b0;
                  strobe_next = 1'b1;
                  state_next  = STROBE;
               end else begin
                  sr_next    = sr_shift;
                  bit_next   = bit_cnt + 1'b1;
                  din_next   = next_bit;
                  state_next = LOW;
               end
            end else begin
               div_next = div_cnt + 1'b1;
            end
         end
         STROBE: begin
            din_next    = 1'b0;
            dclk_next   = 1'b0;
            strobe_next = 1'b1;
            if (div_last) begin
               div_next    = '0;
               strobe_next = 1'b0;
               row_next    = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
               fd_next     = (row_idx == ROW_LAST);
               state_next  = IDLE;
            end else begin
               div_next = div_cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: doc/led_row_serializer.md
# led_row_serializer

Upstream feeder for `tt_um_mjbella_led_matrix_driver`. It accepts one row of pixel data per valid/ready handshake and serializes it onto the driver's `din`/`dclk`/`strobe` inputs. It also holds the per-row blanking value on `blankt`. Row sequencing and frame-boundary pulses are generated here, so a frame buffer or host interface only has to push row words.

## Interface
Parameters:
- `COLS`, 8: bits per row word; legal range 2–64.
- `ROWS`, 8: rows per frame; legal range 2–256.
- `DIV`, 2: system clocks per `dclk` half-period; legal range 1–16.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `row_data`  in  COLS  pixel word; bit COLS-1 is sent first.
- `row_blank`  in  5  blanking time for this row; captured with `row_data`.
- `row_valid`  in  1  upstream has a word.
- `row_ready`  out  1  block can accept a word.
- `din`  out  1  serial data to the driver.
- `dclk`  out  1  serial clock to the driver; the driver samples `din` on the rising edge.
- `strobe`  out  1  latch pulse to the driver.
- `blankt`  out  5  registered blanking value to the driver.
- `row_idx`  out  clog2(ROWS)  index of the row currently being sent or last sent.
- `frame_done`  out  1  one-cycle pulse after the last row's strobe.

## Operation
- States are IDLE, LOW, HIGH and STROBE. Internal state: shift register `sr` (COLS bits), bit counter (clog2(COLS) bits), divider counter (clog2(DIV) bits, minimum 1 bit), row counter.
- IDLE:
  - `row_ready` = 1, decoded combinationally from state and `!rst`.
  - On `row_valid`: load `sr` ← `row_data`, `blankt` ← `row_blank`, bit counter ← 0, divider ← 0; go to LOW.
- LOW:
  - `dclk` = 0; `din` = current bit `sr[COLS-1]`.
  - After DIV cycles, go to HIGH.
- HIGH:
  - `dclk` = 1; `din` unchanged.
  - After DIV cycles: if bit counter = COLS-1, go to STROBE; otherwise shift `sr` left by 1, increment bit counter, go to LOW.
- STROBE:
  - `strobe` = 1, `dclk` = 0, `din` = 0, held for DIV cycles, then return to IDLE.
  - On exit, `row_idx` increments and wraps from ROWS-1 to 0.
  - If `row_idx` was ROWS-1, `frame_done` pulses for exactly 1 cycle, coincident with the first IDLE cycle.
- `din`, `dclk`, `strobe` and `frame_done` are registered outputs; they must not glitch.
- `blankt` changes only on an accepted handshake; it is stable for the whole row and the strobe.
- `row_valid` outside IDLE is ignored; upstream must hold it until `row_ready`.

## Timing
- Reset values:
  - outputs: `din`=0, `dclk`=0, `strobe`=0, `blankt`=0, `row_idx`=0, `frame_done`=0; `row_ready`=0 while `rst`=1.
  - internal: state IDLE, `sr`=0.
- Handshake at edge T. The first `din` bit and LOW state are visible from T+1.
- First `dclk` rise occurs at T+1+DIV.
- Busy time per row: 2·DIV·COLS + DIV cycles. There is at least 1 IDLE cycle between rows, so the minimum row period is 2·DIV·COLS + DIV + 1. Defaults give 8·2·2 + 2 + 1 = 35.
- `din` changes only when `dclk` falls or on entry to LOW: setup = DIV cycles, hold = DIV cycles relative to the `dclk` rise.
- Reset mid-row: at the next edge all outputs return to reset values. The partial row is discarded, no `strobe` is issued, and `row_idx` returns to 0.
- `rst` asserted and `row_valid`=1 in the same cycle: reset wins and nothing is accepted.

## Configuration
- Macro `LED_SER_LSB_FIRST_EN`.
  - Defined: the bit order is reversed, so `row_data[0]` is sent first.
    - Load still happens at the handshake.
    - `din` = `sr[0]` and `sr` shifts right.
  - Undefined: MSB first, as described above.
- Timing, handshake and strobe behaviour are identical in both builds.

## Test plan
1. Reset, then `row_data`=8'hA5, `row_blank`=5'd9, DIV=2 → bits on the `dclk` rises are 1,0,1,0,0,1,0,1; `blankt`=9 from T+1; `strobe` high 2 cycles at T+33..T+34; `row_ready` high again at T+35.
2. `row_valid` held continuously, 8 rows of 8'hFF → `row_idx` steps 0..7 then 0; `frame_done` pulses exactly once, at the IDLE cycle after row 7; row period 35 cycles.
3. Assert `rst` at T+10 during row 8'h3C → next edge `dclk`=`din`=`strobe`=0; no `strobe` ever appears for that row; `row_idx`=0; the next row serializes normally.
4. Pulse `row_valid` with word 8'h00 during LOW/HIGH of an active 8'hF0 row → ignored; the serialized stream remains 1,1,1,1,0,0,0,0 and `blankt` is unchanged.
5. DIV=1, COLS=4, `row_data`=4'b1001 → `dclk` toggles every cycle; 4 rises sample 1,0,0,1; `strobe` 1 cycle; total busy 9 cycles.
6. Build with `LED_SER_LSB_FIRST_EN`, `row_data`=8'h01 → first sampled bit is 1 and the remaining 7 bits are 0.
